// File: rtl/immgen_pipe.sv
// Decode-stage immediate generator: classifies the instruction format, builds the
// extended immediate and queues {imm, fmt, tag} in a 2-entry in-order buffer.
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [4:0]      op;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    assign op       = in_inst[6:2];
    assign funct3   = in_inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_ILL;
        case (op)
            5'b00000, 5'b00011, 5'b11001: begin
                dec_imm = XLEN'($signed(in_inst[31:20]));
                dec_fmt = FMT_I;
            end
            5'b00100: begin
                if (!is_shift) begin
                    dec_imm = XLEN'($signed(in_inst[31:20]));
                    dec_fmt = FMT_I;
                end else if (XLEN == 64) begin
                    dec_imm = XLEN'(in_inst[25:20]);
                    dec_fmt = FMT_I;
                end else if (!in_inst[25]) begin
                    dec_imm = XLEN'(in_inst[24:20]);
                    dec_fmt = FMT_I;
                end
            end
            5'b00110: begin
                // OP-IMM-32 exists only on RV64 and always uses a 5-bit shamt
                if (XLEN == 64) begin
                    if (!is_shift) begin
                        dec_imm = XLEN'($signed(in_inst[31:20]));
                        dec_fmt = FMT_I;
                    end else if (!in_inst[25]) begin
                        dec_imm = XLEN'(in_inst[24:20]);
                        dec_fmt = FMT_I;
                    end
                end
            end
            5'b01000: begin
                dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                dec_fmt = FMT_S;
            end
            5'b11000: begin
                dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
                dec_fmt = FMT_B;
            end
            5'b01101, 5'b00101: begin
                dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
                dec_fmt = FMT_U;
            end
            5'b11011: begin
                dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
                dec_fmt = FMT_J;
            end
            5'b11100: begin
                dec_imm = XLEN'(in_inst[19:15]);
                dec_fmt = FMT_Z;
            end
            5'b01100: dec_fmt = FMT_R;
            5'b01110: begin
                if (XLEN == 64) dec_fmt = FMT_R;
            end
            default: dec_fmt = FMT_ILL;
        endcase
        if (in_inst[1:0] != 2'b11) begin
            dec_imm = '0;
            dec_fmt = FMT_ILL;
        end
    end

    logic [XLEN-1:0]  imm_q [2];
    logic [2:0]       fmt_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       count_q, count_d;
    logic             head_q, head_d;
    logic             wr_idx;
    logic [15:0]      cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2) && !rst;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_idx    = head_q ^ (count_q == 2'd1);

    // The head only moves when another entry will be behind it, so the outputs
    // keep showing the last result once the buffer drains.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        cnt_d   = cnt_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (pop && !push) count_d = count_q - 2'd1;
        if (pop && (push || count_q == 2'd2)) head_d = ~head_q;
        if (push && dec_fmt == FMT_ILL && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            cnt_q   <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= 3'd0;
                tag_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            if (push) begin
                imm_q[wr_idx] <= dec_imm;
                fmt_q[wr_idx] <= dec_fmt;
                tag_q[wr_idx] <= in_tag;
            end
        end
    end

    assign out_imm     = imm_q[head_q];
    assign out_fmt     = fmt_q[head_q];
    assign out_tag     = tag_q[head_q];
    assign out_illegal = (fmt_q[head_q] == FMT_ILL);
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Parametrised, flow-controlled immediate generator for the decode stage. It accepts one instruction word per cycle on a valid/ready input and classifies its format. It also produces the sign- or zero-extended immediate for every base integer format (I, S, B, U, J, CSR-zimm), and flags unsupported encodings. Results pass through a 2-entry in-order buffer, so the block absorbs one cycle of downstream back-pressure without losing throughput. A sideband tag, for example the PC or ROB index, travels alongside each instruction.

## Interface
- XLEN, 32: immediate/output width; legal values 32, 64.
- TAG_W, 32: width of the pass-through tag.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  instruction word presented.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format: 0 none(R), 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z(CSR zimm), 7 illegal.
- out_illegal  out  1  equals (out_fmt == 7).
- out_tag  out  TAG_W  tag of the result.
- illegal_cnt  out  16  saturating count of accepted illegal words.

## Operation
- Push when in_valid & in_ready; pop when out_valid & out_ready. Decode is combinational on in_inst; the result is written into the buffer on push.
- The decode key is op = in_inst[6:2]. When in_inst[1:0] != 2'b11, the word is illegal.
- I: op 00000 (LOAD), 00011 (MISC-MEM), 11001 (JALR), 00100 (OP-IMM) → sext(inst[31:20]).
- OP-IMM shifts, funct3 = 001 or 101 → zext(inst[24:20]) when XLEN=32, zext(inst[25:20]) when XLEN=64. With XLEN=32, inst[25]=1 is illegal.
- S: op 01000 → sext({inst[31:25], inst[11:7]}).
- B: op 11000 → sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- U: op 01101 (LUI), 00101 (AUIPC) → sext({inst[31:12], 12'b0}); sign-extension matters only when XLEN=64.
- J: op 11011 → sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Z: op 11100 (SYSTEM) → zext(inst[19:15]).
- R: op 01100 (OP) → imm 0.
- XLEN=64 only: op 00110 (OP-IMM-32) is I-type with 5-bit shamt rules. op 01110 (OP-32) is R.
- Any other op is illegal: imm 0, fmt 7.
- Buffer: 2 entries, FIFO order, with occupancy count ∈ {0, 1, 2}. in_ready = (count != 2) & !rst. out_valid = (count != 0). The out_* fields show the head entry and are held stable while out_valid & !out_ready.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged, head advances and the new entry is written behind it. With count 2, no push can occur.
- illegal_cnt increments on each push of an illegal word and saturates at 16'hFFFF.

## Timing
- Latency: a word pushed at edge N is visible with out_valid=1 in the cycle after N, when the buffer was empty.
- Throughput is 1 per cycle while out_ready=1. A single cycle of out_ready=0 fills the second entry and causes no input stall. A second consecutive stalled cycle drops in_ready.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Reset, applied at any edge including mid-stream: count ← 0 and illegal_cnt ← 0; buffered entries are discarded. out_valid=0, out_imm=0, out_fmt=0, out_tag=0, out_illegal=0. in_ready is 0 while rst=1 and 1 in the first cycle after.
- Data fields are don't-care-free: out_imm, out_fmt and out_tag hold their last value when out_valid=0, with 0 after reset.

## Test plan
- Reset then push 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, imm=0x00000005, fmt=1. Push 0xFFF00093 → imm=0xFFFFFFFF.
- Format sweep at XLEN=32: sw 0xFE112E23 → imm=0xFFFFFFFC, fmt 2. beq 0xFE000EE3 → 0xFFFFFFFC, fmt 3. lui 0x800000B7 → 0x80000000, fmt 4. jal 0x0080006F → 0x00000008, fmt 5. csrrwi 0x3400D073 → 0x00000001, fmt 6.
- XLEN=64: lui 0x800000B7 → 0xFFFFFFFF80000000. slli 0x03F09093 → imm 63, fmt 1. At XLEN=32 the same word gives fmt 7 and illegal_cnt=1.
- Back-pressure: stream 4 words with out_ready low for 2 cycles. in_ready stays 1 for the first stall cycle and falls on the second. All 4 outputs arrive in order with correct tags and none are duplicated or dropped.
- Illegal words 0x00000000 and 0x0000007B → fmt 7, imm 0, out_illegal=1. Force 65540 illegal pushes → illegal_cnt saturates at 0xFFFF.
- Assert rst with count=2 → next cycle out_valid=0, all outputs 0, in_ready=1 after rst drops. The old entries never appear.
